// File: rtl/sampler_play_pkg.sv
// Shared types and constants for the sample-playback controller:
// FSM state encoding, command opcodes and command-byte field positions.
package sampler_play_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_FETCH = 2'd2,
        ST_WAIT  = 2'd3
    } state_t;

    localparam logic [1:0] OP_NOP      = 2'b00;
    localparam logic [1:0] OP_PLAY     = 2'b01;
    localparam logic [1:0] OP_STOP     = 2'b10;
    localparam logic [1:0] OP_SET_GAIN = 2'b11;

    localparam int CMD_TOGGLE_BIT = 7;
    localparam int CMD_OP_HI      = 6;
    localparam int CMD_OP_LO      = 5;
    localparam int CMD_LOOP_BIT   = 4;
    localparam int CMD_SLOT_HI    = 3;
    localparam int CMD_SLOT_LO    = 0;
    localparam int CMD_GAIN_HI    = 2;
    localparam int CMD_GAIN_LO    = 0;

endpackage

// File: rtl/sampler_cmd_detect.sv
// Command toggle detection and opcode decode for sampler_play_ctrl.
// A command is new whenever the toggle bit differs from the last
// acknowledged toggle. Optional feature macro: SAMPLER_LOOP_EN
// (exposes the loop request bit of a PLAY command).
module sampler_cmd_detect
    import sampler_play_pkg::*;
(
    input  logic [7:0] cmd_in,
    input  logic       cmd_ack,
`ifdef SAMPLER_LOOP_EN
    output logic       loop_arg,
`endif
    output logic       cmd_new,
    output logic       op_play,
    output logic       op_stop,
    output logic       op_gain,
    output logic [3:0] slot,
    output logic [2:0] gain_arg
);

    logic [1:0] opcode;

    assign opcode   = cmd_in[CMD_OP_HI:CMD_OP_LO];
    assign cmd_new  = cmd_in[CMD_TOGGLE_BIT] != cmd_ack;
    assign op_play  = opcode == OP_PLAY;
    assign op_stop  = opcode == OP_STOP;
    assign op_gain  = opcode == OP_SET_GAIN;
    assign slot     = cmd_in[CMD_SLOT_HI:CMD_SLOT_LO];
    assign gain_arg = cmd_in[CMD_GAIN_HI:CMD_GAIN_LO];

`ifdef SAMPLER_LOOP_EN
    assign loop_arg = cmd_in[CMD_LOOP_BIT];
`else
    // Loop request bit has no meaning without looping support
    logic unused_loop_bit;
    assign unused_loop_bit = cmd_in[CMD_LOOP_BIT];
`endif

endmodule

// File: rtl/sampler_play_ctrl.sv
// Sample playback controller: takes toggle-handshaked commands from a PIO
// byte, fetches one sample word per sample_tick from a slot in memory,
// scales it by an arithmetic right shift and strobes it out.
// Optional feature macro: SAMPLER_LOOP_EN (PLAY arg[4] selects looping
// playback of the slot instead of stopping at its end).
module sampler_play_ctrl
    import sampler_play_pkg::*;
#(
    parameter int ADDR_W     = 16,
    parameter int SLOT_SHIFT = 12
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [7:0]        cmd_in,
    input  logic              sample_tick,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_read,
    input  logic              mem_waitrequest,
    input  logic [15:0]       mem_readdata,
    input  logic              mem_rvalid,
    output logic [15:0]       audio_out,
    output logic              audio_valid,
    output logic              busy,
    output logic              underrun,
    output logic              cmd_ack
);

    if (ADDR_W < SLOT_SHIFT + 4) begin : g_bad_params
        $error("sampler_play_ctrl: ADDR_W must be at least SLOT_SHIFT+4");
    end

    state_t            state, state_next;
    logic [ADDR_W-1:0] addr, addr_next;
    logic [2:0]        gain, gain_next;
    logic              underrun_next;
    logic              cmd_ack_next;
    logic              audio_load;
    logic [15:0]       audio_scaled;

    logic              cmd_new;
    logic              op_play;
    logic              op_stop;
    logic              op_gain;
    logic [3:0]        slot;
    logic [2:0]        gain_arg;
    logic              accept;
    logic              slot_end;
    logic [ADDR_W-1:0] slot_base;

`ifdef SAMPLER_LOOP_EN
    logic              loop_arg;
    logic              loop_flag, loop_flag_next;
`endif

    sampler_cmd_detect u_cmd_detect (
        .cmd_in   (cmd_in),
        .cmd_ack  (cmd_ack),
`ifdef SAMPLER_LOOP_EN
        .loop_arg (loop_arg),
`endif
        .cmd_new  (cmd_new),
        .op_play  (op_play),
        .op_stop  (op_stop),
        .op_gain  (op_gain),
        .slot     (slot),
        .gain_arg (gain_arg)
    );

    // Commands are only taken while no memory transfer is outstanding
    assign accept       = cmd_new && (state == ST_IDLE || state == ST_ARMED);
    assign slot_end     = &addr[SLOT_SHIFT-1:0];
    assign slot_base    = {{(ADDR_W-4){1'b0}}, slot} << SLOT_SHIFT;
    assign audio_scaled = $signed(mem_readdata) >>> gain;

    assign mem_read = state == ST_FETCH;
    assign mem_addr = addr;
    assign busy     = state != ST_IDLE;

    // Next-state logic: command handling, tick-driven fetch and slot walk
    always_comb begin
        state_next    = state;
        addr_next     = addr;
        gain_next     = gain;
        underrun_next = underrun;
        cmd_ack_next  = cmd_ack;
        audio_load    = 1'b0;
`ifdef SAMPLER_LOOP_EN
        loop_flag_next = loop_flag;
`endif

        if (accept) begin
            cmd_ack_next = cmd_in[CMD_TOGGLE_BIT];
            if (op_play) begin
                addr_next     = slot_base;
                underrun_next = 1'b0;
                state_next    = ST_ARMED;
`ifdef SAMPLER_LOOP_EN
                loop_flag_next = loop_arg;
`endif
            end else if (op_stop) begin
                state_next = ST_IDLE;
            end else if (op_gain) begin
                gain_next = gain_arg;
            end
        end

        case (state)
            ST_ARMED: begin
                // A PLAY or STOP taken this cycle wins and the tick is dropped
                if (sample_tick && !(accept && (op_play || op_stop))) begin
                    state_next = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (sample_tick) begin
                    underrun_next = 1'b1;
                end
                if (!mem_waitrequest) begin
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (sample_tick) begin
                    underrun_next = 1'b1;
                end
                if (mem_rvalid) begin
                    audio_load = 1'b1;
                    if (slot_end) begin
`ifdef SAMPLER_LOOP_EN
                        if (loop_flag) begin
                            addr_next                 = addr;
                            addr_next[SLOT_SHIFT-1:0] = '0;
                            state_next                = ST_ARMED;
                        end else begin
                            state_next = ST_IDLE;
                        end
`else
                        state_next = ST_IDLE;
`endif
                    end else begin
                        addr_next  = addr + ADDR_W'(1);
                        state_next = ST_ARMED;
                    end
                end
            end
            default: begin
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously on reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            addr        <= '0;
            gain        <= '0;
            underrun    <= 1'b0;
            cmd_ack     <= 1'b0;
            audio_out   <= '0;
            audio_valid <= 1'b0;
`ifdef SAMPLER_LOOP_EN
            loop_flag   <= 1'b0;
`endif
        end else begin
            state       <= state_next;
            addr        <= addr_next;
            gain        <= gain_next;
            underrun    <= underrun_next;
            cmd_ack     <= cmd_ack_next;
            audio_valid <= audio_load;
            if (audio_load) begin
                audio_out <= audio_scaled;
            end
`ifdef SAMPLER_LOOP_EN
            loop_flag   <= loop_flag_next;
`endif
        end
    end

endmodule

// File: tb/tb_sampler_play_ctrl.sv
// Directed testbench for sampler_play_ctrl. Inputs are driven and outputs
// checked 1 ns after each rising clock edge. Honours SAMPLER_LOOP_EN.
module tb_sampler_play_ctrl;

    logic        clk;
    logic        reset_n;
    logic [7:0]  cmd_in;
    logic        sample_tick;
    logic [15:0] mem_addr;
    logic        mem_read;
    logic        mem_waitrequest;
    logic [15:0] mem_readdata;
    logic        mem_rvalid;
    logic [15:0] audio_out;
    logic        audio_valid;
    logic        busy;
    logic        underrun;
    logic        cmd_ack;

    int tests_run = 0;
    int tests_failed = 0;

    sampler_play_ctrl #(.ADDR_W(16), .SLOT_SHIFT(12)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .cmd_in          (cmd_in),
        .sample_tick     (sample_tick),
        .mem_addr        (mem_addr),
        .mem_read        (mem_read),
        .mem_waitrequest (mem_waitrequest),
        .mem_readdata    (mem_readdata),
        .mem_rvalid      (mem_rvalid),
        .audio_out       (audio_out),
        .audio_valid     (audio_valid),
        .busy            (busy),
        .underrun        (underrun),
        .cmd_ack         (cmd_ack)
    );

    // Free-running 100 MHz clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance n clock edges, landing 1 ns after the last rising edge
    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One comparison: counts it and reports any difference
    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // One sample read: tick into FETCH, accepted into WAIT, rvalid back out
    task automatic one_read(input logic [15:0] data);
        sample_tick = 1'b1;
        step();
        sample_tick = 1'b0;
        step();
        mem_rvalid   = 1'b1;
        mem_readdata = data;
        step();
        mem_rvalid = 1'b0;
    endtask

    // Directed sequence
    initial begin
        reset_n         = 1'b0;
        cmd_in          = 8'h00;
        sample_tick     = 1'b0;
        mem_waitrequest = 1'b0;
        mem_readdata    = 16'h0000;
        mem_rvalid      = 1'b0;
        step(3);

        check_output("reset_busy", busy, 0);
        check_output("reset_cmd_ack", cmd_ack, 0);
        check_output("reset_mem_read", mem_read, 0);
        check_output("reset_mem_addr", mem_addr, 0);
        check_output("reset_audio_out", audio_out, 0);
        check_output("reset_audio_valid", audio_valid, 0);
        check_output("reset_underrun", underrun, 0);
        reset_n = 1'b1;
        step();
        check_output("idle_after_reset_busy", busy, 0);

        // PLAY slot 3
        cmd_in = 8'hA3;
        step();
        check_output("play_busy", busy, 1);
        check_output("play_cmd_ack", cmd_ack, 1);
        check_output("play_no_read_yet", mem_read, 0);

        // SET_GAIN 2
        cmd_in = 8'h62;
        step();
        check_output("gain_cmd_ack", cmd_ack, 0);
        check_output("gain_still_armed", busy, 1);

        // First fetch at slot base
        sample_tick = 1'b1;
        step();
        sample_tick = 1'b0;
        check_output("fetch_mem_read", mem_read, 1);
        check_output("fetch_mem_addr", mem_addr, 32'h3000);
        step();
        check_output("wait_mem_read_low", mem_read, 0);
        mem_rvalid   = 1'b1;
        mem_readdata = 16'h8000;
        step();
        mem_rvalid = 1'b0;
        check_output("scaled_audio", audio_out, 32'hE000);
        check_output("audio_valid_strobe", audio_valid, 1);
        check_output("addr_increment", mem_addr, 32'h3001);
        step();
        check_output("audio_valid_one_cycle", audio_valid, 0);
        check_output("audio_hold", audio_out, 32'hE000);

        // Wait-stalled fetch with a tick arriving mid-stall
        mem_waitrequest = 1'b1;
        sample_tick     = 1'b1;
        step();
        sample_tick = 1'b0;
        step();
        sample_tick = 1'b1;
        step();
        sample_tick = 1'b0;
        step(2);
        check_output("stall_mem_read", mem_read, 1);
        check_output("stall_mem_addr", mem_addr, 32'h3001);
        check_output("stall_underrun", underrun, 1);
        mem_waitrequest = 1'b0;
        step();
        mem_rvalid   = 1'b1;
        mem_readdata = 16'h1234;
        step();
        mem_rvalid = 1'b0;
        check_output("stall_audio", audio_out, 32'h048D);
        check_output("underrun_sticky", underrun, 1);
        cmd_in = 8'hA3;
        step();
        check_output("play_clears_underrun", underrun, 0);
        check_output("play_restart_addr", mem_addr, 32'h3000);

        // NOP while armed
        cmd_in = 8'h00;
        step();
        check_output("nop_cmd_ack", cmd_ack, 0);
        check_output("nop_keeps_armed", busy, 1);

        // STOP held pending while in WAIT
        sample_tick = 1'b1;
        step();
        sample_tick = 1'b0;
        step();
        cmd_in = 8'hC0;
        step(2);
        check_output("stop_pending_ack", cmd_ack, 0);
        check_output("stop_pending_busy", busy, 1);
        mem_rvalid   = 1'b1;
        mem_readdata = 16'h0100;
        step();
        mem_rvalid = 1'b0;
        check_output("stop_rvalid_audio", audio_out, 32'h0040);
        check_output("stop_still_pending", cmd_ack, 0);
        step();
        check_output("stop_accepted_ack", cmd_ack, 1);
        check_output("stop_idle", busy, 0);

        // Walk the whole of slot 3 to its end
`ifdef SAMPLER_LOOP_EN
        cmd_in = 8'h33;
`else
        cmd_in = 8'h23;
`endif
        step();
        for (int i = 0; i < 4095; i++) begin
            one_read(16'h0400);
        end
        sample_tick = 1'b1;
        step();
        sample_tick = 1'b0;
        check_output("last_word_addr", mem_addr, 32'h3FFF);
        step();
        mem_rvalid = 1'b1;
        step();
        mem_rvalid = 1'b0;
        check_output("slot_end_audio_valid", audio_valid, 1);
`ifdef SAMPLER_LOOP_EN
        check_output("slot_end_loop_busy", busy, 1);
        sample_tick = 1'b1;
        step();
        sample_tick = 1'b0;
        check_output("loop_reload_addr", mem_addr, 32'h3000);
        check_output("loop_reload_read", mem_read, 1);
        step();
        mem_rvalid = 1'b1;
        step();
        mem_rvalid = 1'b0;
`else
        check_output("slot_end_idle", busy, 0);
`endif

        // PLAY concurrent with a tick: PLAY wins, tick dropped
        cmd_in = 8'hA1;
        step();
        check_output("play_slot1_addr", mem_addr, 32'h1000);
        cmd_in      = 8'h22;
        sample_tick = 1'b1;
        step();
        sample_tick = 1'b0;
        check_output("play_wins_no_read", mem_read, 0);
        check_output("play_wins_addr", mem_addr, 32'h2000);
        check_output("play_wins_no_underrun", underrun, 0);

        // SET_GAIN concurrent with a tick: tick still fetches
        cmd_in          = 8'hE0;
        sample_tick     = 1'b1;
        mem_waitrequest = 1'b1;
        step();
        sample_tick = 1'b0;
        check_output("gain_tick_read", mem_read, 1);
        check_output("gain_tick_ack", cmd_ack, 1);

        // rvalid outside WAIT is ignored
        mem_rvalid   = 1'b1;
        mem_readdata = 16'h7FFF;
        step();
        mem_rvalid = 1'b0;
        check_output("stray_rvalid_valid", audio_valid, 0);
        check_output("stray_rvalid_hold", audio_out, 32'h0100);

        // Reset mid-fetch abandons the read
        cmd_in  = 8'h20;
        reset_n = 1'b0;
        #1;
        check_output("midreset_mem_read", mem_read, 0);
        check_output("midreset_mem_addr", mem_addr, 0);
        check_output("midreset_busy", busy, 0);
        check_output("midreset_audio_out", audio_out, 0);
        check_output("midreset_cmd_ack", cmd_ack, 0);
        step();
        reset_n         = 1'b1;
        mem_waitrequest = 1'b0;
        mem_rvalid      = 1'b1;
        step();
        mem_rvalid = 1'b0;
        check_output("post_reset_no_valid", audio_valid, 0);
        step();
        check_output("post_reset_idle", busy, 0);
        check_output("post_reset_no_cmd", cmd_ack, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/sampler_play_ctrl.md
SAMPLER_PLAY_CTRL -- requirements
Module: sampler_play_ctrl

Interface
REQ-001 Parameter ADDR_W, default 16: sample memory word-address width.
REQ-002 Parameter SLOT_SHIFT, default 12: log2 of words per slot; ADDR_W SHALL be >= SLOT_SHIFT+4.
REQ-003 clk  input  1  clock; all logic SHALL be on rising edge of clk.
REQ-004 reset_n  input  1  reset, asynchronous, active-low.
REQ-005 cmd_in  input  8  command byte from the PIO output port, same clock domain: [7] toggle, [6:5] opcode, [4:0] arg.
REQ-006 sample_tick  input  1  one-cycle sample-rate strobe.
REQ-007 mem_addr  output  ADDR_W  word address of the current read.
REQ-008 mem_read  output  1  read request, held until accepted.
REQ-009 mem_waitrequest  input  1  read not accepted this cycle.
REQ-010 mem_readdata  input  16  signed sample word.
REQ-011 mem_rvalid  input  1  readdata valid; exactly one per accepted read.
REQ-012 audio_out  output  16  signed scaled sample; audio_valid  output  1  one-cycle strobe.
REQ-013 busy  output  1  high when state != IDLE; underrun  output  1  sticky; cmd_ack  output  1  last accepted toggle value.

Function
REQ-014 A new command SHALL exist when cmd_in[7] != cmd_ack; acceptance SHALL copy cmd_in[7] to cmd_ack on the next edge.
REQ-015 Opcodes SHALL be 00 NOP, 01 PLAY (arg[3:0] slot), 10 STOP, 11 SET_GAIN (arg[2:0] right-shift 0..7).
REQ-016 Commands SHALL be accepted only in IDLE and ARMED; in FETCH/WAIT they SHALL stay pending until return to ARMED/IDLE.
REQ-017 FSM states SHALL be IDLE, ARMED, FETCH, WAIT.
REQ-018 PLAY SHALL load addr = slot << SLOT_SHIFT, clear underrun, enter ARMED; in ARMED it restarts at the new slot.
REQ-019 STOP SHALL enter IDLE; SET_GAIN and NOP SHALL not change state.
REQ-020 ARMED with sample_tick SHALL enter FETCH; a PLAY/STOP accepted the same cycle SHALL take priority and drop the tick without setting underrun; a concurrent SET_GAIN/NOP SHALL not block the tick.
REQ-021 In FETCH mem_read SHALL be 1 with mem_addr = addr; when mem_waitrequest=0 SHALL enter WAIT.
REQ-022 In WAIT on mem_rvalid: audio_out <= arithmetic-right-shift(mem_readdata, gain), audio_valid = 1 on the following cycle only.
REQ-023 At the same rvalid: if addr[SLOT_SHIFT-1:0] is all ones, the slot ends (see REQ-028); otherwise addr increments by 1 and state enters ARMED.
REQ-024 sample_tick while in FETCH or WAIT SHALL set underrun; only PLAY or reset clears it.
REQ-025 mem_rvalid outside WAIT SHALL be ignored; audio_out SHALL hold its value between strobes.

Reset
REQ-026 On reset_n low: state IDLE, addr 0, gain 0, mem_read 0, mem_addr 0, audio_out 0, audio_valid 0, underrun 0, cmd_ack 0, busy 0.
REQ-027 Reset mid-read SHALL abandon the transfer; no command SHALL be detected after reset while cmd_in[7]=0.

Configuration
REQ-028 With SAMPLER_LOOP_EN defined, PLAY arg[4]=1 SHALL latch a loop flag and slot end SHALL reload the slot base and enter ARMED; with arg[4]=0, or without the macro (arg[4] ignored), slot end SHALL enter IDLE.

Structure
REQ-029 Package sampler_play_pkg SHALL hold the state enum, opcode constants, and the command-field bit positions.
REQ-030 Toggle detection and opcode decode SHALL be the sub-module sampler_cmd_detect.

Verification
REQ-031 cmd_in 0x00->0xA3 (PLAY slot 3) -> busy=1, cmd_ack=1; next tick -> mem_read with mem_addr=0x3000.
REQ-032 readdata 0x8000, gain 2 (cmd 0x62 toggled) -> audio_out=0xE000, one-cycle audio_valid.
REQ-033 Slot end at 0x3FFF, loop flag clear -> IDLE, busy=0; SAMPLER_LOOP_EN with arg[4]=1 -> next read at 0x3000.
REQ-034 mem_waitrequest held 5 cycles, tick arrives during it -> mem_read held, address stable, underrun=1; later PLAY clears underrun.
REQ-035 STOP (0xC0) sent while in WAIT -> cmd_ack unchanged until rvalid; after rvalid -> STOP accepted, IDLE.
REQ-036 reset_n low during FETCH -> all outputs at reset values; a subsequent rvalid produces no audio_valid.
